// File: rtl/factorial_seq_engine.sv
// Multi-cycle factorial engine: one W x N multiply per clock, valid/ready on
// both sides, sticky overflow flag for results that exceed W bits.
module factorial_seq_engine #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] n_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     acc;
  logic [N-1:0]     cnt;
  logic             ovf;
  logic [W+N-1:0]   prod;
  logic             last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last_step = (cnt <= N'(1));

  always_comb begin
    prod      = {{N{1'b0}}, acc} * {{W{1'b0}}, cnt};
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Multiplying from n downward means acc*cnt never exceeds W+N bits, so any
  // nonzero upper slice marks the first step where the true n! overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= W'(1);
      cnt      <= '0;
      ovf      <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt <= n_in;
            acc <= W'(1);
            ovf <= 1'b0;
          end
        end
        CALC: begin
          if (last_step) begin
            result   <= acc;
            overflow <= ovf;
          end else begin
            acc <= prod[W-1:0];
            cnt <= cnt - 1'b1;
            ovf <= ovf | (|prod[W+N-1:W]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_seq_engine.sv
// Scoreboard bench for factorial_seq_engine: driver pushes hand-computed
// expectations, a negedge monitor checks result, overflow, latency and hold.
module tb_factorial_seq_engine;

  localparam int unsigned N = 8;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] n_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         overflow;

  factorial_seq_engine #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n_in      (n_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] n;
    logic [W-1:0] res;
    logic         ovf;
    int unsigned  lat;
    int unsigned  acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          head_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle with out_valid, head entry must match (covers hold
  // under backpressure); pop when the consumer takes it.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out_valid: out_valid=1 with no operand pending (t=%0t)", $time);
      end else begin
        check($sformatf("result_n%0d", sb[0].n), result, sb[0].res);
        check($sformatf("overflow_n%0d", sb[0].n), W'(overflow), W'(sb[0].ovf));
        if (!head_seen) begin
          check($sformatf("latency_n%0d", sb[0].n), W'(cyc - sb[0].acc_cyc), W'(sb[0].lat));
          head_seen = 1'b1;
        end
        if (out_ready) begin
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [N-1:0] n, input logic [W-1:0] res, input logic ovf);
    exp_t e;
    int unsigned waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    n_in     = n;
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout_n%0d: in_ready stayed 0, expected 1", n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_in     = 8'hA5;
      e.n = n; e.res = res; e.ovf = ovf;
      e.lat = (n == 0) ? 1 : int'(n);
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int unsigned waited = 0;
    while (sb.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", W'(sb.size()), '0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  W'(in_ready),  W'(1));
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_result"},    result,        '0);
    check({tag, "_overflow"},  W'(overflow),  W'(0));
  endtask

  initial begin
    int unsigned waited;

    // Reset
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_release");

    // Basic, edge and overflow operands
    send(8'd4,  32'd24,        1'b0);
    send(8'd5,  32'd120,       1'b0);
    send(8'd0,  32'd1,         1'b0);
    send(8'd1,  32'd1,         1'b0);
    send(8'd9,  32'h0005_8980, 1'b0);
    send(8'd12, 32'h1C8C_FC00, 1'b0);
    send(8'd13, 32'h7328_CC00, 1'b1);
    send(8'd3,  32'd6,         1'b0);
    drain();

    // Backpressure: result must hold while in_valid is pulsed and ignored
    out_ready = 1'b0;
    send(8'd5, 32'd120, 1'b0);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("bp_out_valid_seen", W'(out_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      n_in     = 8'd7;
      @(negedge clk);
      check("bp_in_ready_low", W'(in_ready), W'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset mid-CALC: abort, no output for the dropped operand
    @(negedge clk);
    in_valid = 1'b1;
    n_in     = 8'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_calc", W'(in_ready), W'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_output", W'(out_valid), W'(0));

    // Engine still works after abort
    send(8'd6, 32'd720, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
